// File: rtl/sprite_pkg.sv
// sprite_pkg: shared animation state type and the four-frame breaking-heart bitmap ROM.
// Each row is MSB-leftmost; frame index 0 is the intact heart and frame 3 the fully broken one.
package sprite_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} anim_state_t;
    localparam int HEART_W = 3;
    localparam int HEART_H = 4;
    localparam int HEART_N = 4;
    typedef logic [HEART_W-1:0] frame_t [HEART_H];
    localparam frame_t HEART_FRAMES [HEART_N] = '{
        '{3'b101, 3'b111, 3'b111, 3'b010},
        '{3'b101, 3'b111, 3'b011, 3'b010},
        '{3'b101, 3'b011, 3'b101, 3'b010},
        '{3'b100, 3'b001, 3'b100, 3'b010}
    };
endpackage

// File: rtl/sprite_frame_rom.sv
// sprite_frame_rom: registered (frame, row, col) bitmap lookup, second stage of the pixel pipeline.
module sprite_frame_rom
    import sprite_pkg::*;
#(
    parameter int FW = 2,
    parameter int RW = 2,
    parameter int CW = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          en_i,
    input  logic [FW-1:0] frame_i,
    input  logic [RW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic          pix_o
);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) pix_o <= 1'b0;
        else         pix_o <= en_i & HEART_FRAMES[frame_i][row_i][col_i];
    end
endmodule

// File: rtl/anim_sprite_renderer.sv
// anim_sprite_renderer: animated, scaled, mirrorable bitmap sprite with a 2-cycle pixel pipeline.
// Define SPRITE_FLIP_V_EN to add the flip_v_in port and vertical flipping.
module anim_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int BMP_W       = 3,
    parameter int BMP_H       = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int N_FRAMES    = 4,
    parameter int FRAME_HOLD  = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [10:0]                 x_in,
    input  logic [9:0]                  y_in,
    input  logic [10:0]                 hcount_in,
    input  logic [9:0]                  vcount_in,
    input  logic                        mirror_in,
`ifdef SPRITE_FLIP_V_EN
    input  logic                        flip_v_in,
`endif
    input  logic                        new_frame_in,
    input  logic                        start_in,
    input  logic                        loop_in,
    output logic                        in_sprite,
    output logic [$clog2(N_FRAMES)-1:0] frame_idx,
    output logic                        busy,
    output logic                        done
);
    localparam int FW = $clog2(N_FRAMES);
    localparam int HW = FRAME_HOLD > 1 ? $clog2(FRAME_HOLD) : 1;
    localparam int CW = BMP_W > 1 ? $clog2(BMP_W) : 1;
    localparam int RW = BMP_H > 1 ? $clog2(BMP_H) : 1;
    localparam logic [10:0] W_PX = 11'(BMP_W << SCALE_SHIFT);
    localparam logic [9:0]  H_PX = 10'(BMP_H << SCALE_SHIFT);

    anim_state_t   state_q;
    logic [FW-1:0] frame_q, frame_s1_q;
    logic [HW-1:0] hold_q;
    logic          loop_q, done_q, mirror_q, hit_q;
    logic [10:0]   x_q, rel_x;
    logic [9:0]    y_q, rel_y;
    logic [CW-1:0] col_raw, col_d, col_q;
    logic [RW-1:0] row_raw, row_d, row_q;

    // Negative offsets wrap to large unsigned values, so one compare per axis bounds the box.
    assign rel_x   = hcount_in - x_q;
    assign rel_y   = vcount_in - y_q;
    assign col_raw = CW'(rel_x >> SCALE_SHIFT);
    assign row_raw = RW'(rel_y >> SCALE_SHIFT);
    assign col_d   = mirror_q ? col_raw : CW'(BMP_W - 1) - col_raw;

`ifdef SPRITE_FLIP_V_EN
    logic flip_v_q;
    assign row_d = flip_v_q ? RW'(BMP_H - 1) - row_raw : row_raw;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)           flip_v_q <= 1'b0;
        else if (new_frame_in) flip_v_q <= flip_v_in;
    end
`else
    assign row_d = row_raw;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            hold_q     <= '0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            mirror_q   <= 1'b0;
            hit_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            frame_s1_q <= '0;
        end else begin
            done_q     <= 1'b0;
            hit_q      <= (rel_x < W_PX) && (rel_y < H_PX) && (state_q != IDLE);
            row_q      <= row_d;
            col_q      <= col_d;
            frame_s1_q <= frame_q;
            if (new_frame_in) begin
                x_q      <= x_in;
                y_q      <= y_in;
                mirror_q <= mirror_in;
            end
            // A restart swallows any coincident frame tick.
            if (start_in) begin
                state_q <= PLAY;
                frame_q <= '0;
                hold_q  <= '0;
                loop_q  <= loop_in;
            end else if (state_q == PLAY && new_frame_in) begin
                if (hold_q == HW'(FRAME_HOLD - 1)) begin
                    hold_q <= '0;
                    if (frame_q != FW'(N_FRAMES - 1)) frame_q <= frame_q + 1'b1;
                    else if (loop_q)                  frame_q <= '0;
                    else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end else begin
                    hold_q <= hold_q + 1'b1;
                end
            end
        end
    end

    sprite_frame_rom #(.FW(FW), .RW(RW), .CW(CW)) u_rom (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_i    (hit_q),
        .frame_i (frame_s1_q),
        .row_i   (row_q),
        .col_i   (col_q),
        .pix_o   (in_sprite)
    );

    assign frame_idx = frame_q;
    assign busy      = (state_q == PLAY);
    assign done      = done_q;
endmodule

// File: tb/tb_anim_sprite_renderer.sv
// tb_anim_sprite_renderer: directed pixel vector table plus animation, restart and reset sequences.
module tb_anim_sprite_renderer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x, h;
    logic [9:0]  y, v;
    logic        mirror, flip_v, nf, start, loop;
    logic        in_sprite, busy, done;
    logic [1:0]  frame_idx;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    anim_sprite_renderer dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .x_in         (x),
        .y_in         (y),
        .hcount_in    (h),
        .vcount_in    (v),
        .mirror_in    (mirror),
`ifdef SPRITE_FLIP_V_EN
        .flip_v_in    (flip_v),
`endif
        .new_frame_in (nf),
        .start_in     (start),
        .loop_in      (loop),
        .in_sprite    (in_sprite),
        .frame_idx    (frame_idx),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [10:0] h;
        logic [9:0]  v;
        logic        m;
        logic        exp;
    } vec_t;
    vec_t vt [17];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            nf = 1'b1;
            tick();
            nf = 1'b0;
            tick();
        end
    endtask

    initial begin
        vt[0]  = '{11'd100,  10'd50, 11'd100,  10'd50, 1'b0, 1'b1};
        vt[1]  = '{11'd100,  10'd50, 11'd104,  10'd50, 1'b0, 1'b0};
        vt[2]  = '{11'd100,  10'd50, 11'd108,  10'd50, 1'b0, 1'b1};
        vt[3]  = '{11'd100,  10'd50, 11'd112,  10'd50, 1'b0, 1'b0};
        vt[4]  = '{11'd100,  10'd50, 11'd108,  10'd50, 1'b1, 1'b1};
        vt[5]  = '{11'd100,  10'd50, 11'd112,  10'd50, 1'b1, 1'b0};
        vt[6]  = '{11'd100,  10'd50, 11'd100,  10'd50, 1'b1, 1'b1};
        vt[7]  = '{11'd100,  10'd50, 11'd100,  10'd62, 1'b0, 1'b0};
        vt[8]  = '{11'd100,  10'd50, 11'd104,  10'd65, 1'b0, 1'b1};
        vt[9]  = '{11'd100,  10'd50, 11'd104,  10'd66, 1'b0, 1'b0};
        vt[10] = '{11'd100,  10'd50, 11'd104,  10'd49, 1'b0, 1'b0};
        vt[11] = '{11'd5,    10'd0,  11'd2,    10'd0,  1'b0, 1'b0};
        vt[12] = '{11'd2040, 10'd0,  11'd2044, 10'd12, 1'b0, 1'b1};
        vt[13] = '{11'd2040, 10'd0,  11'd2047, 10'd15, 1'b0, 1'b1};
        vt[14] = '{11'd2040, 10'd0,  11'd0,    10'd12, 1'b0, 1'b0};
        vt[15] = '{11'd2040, 10'd0,  11'd2040, 10'd12, 1'b0, 1'b0};
        vt[16] = '{11'd100,  10'd50, 11'd104,  10'd54, 1'b0, 1'b1};

        {x, y, h, v, mirror, flip_v, nf, start, loop} = '0;
        rst_n = 1'b0;
        tick(2);
        chk("reset_in_sprite", int'(in_sprite), 0);
        chk("reset_frame", int'(frame_idx), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;

        x = 11'd100; y = 10'd50;
        nf = 1'b1; tick(); nf = 1'b0;
        h = 11'd100; v = 10'd50;
        tick(3);
        chk("idle_gated", int'(in_sprite), 0);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 17; i++) begin
            x = vt[i].x; y = vt[i].y; mirror = vt[i].m;
            nf = 1'b1; start = 1'b1; loop = 1'b0;
            tick();
            nf = 1'b0; start = 1'b0;
            h = vt[i].h; v = vt[i].v;
            tick(2);
            chk($sformatf("vec%0d_pixel", i), int'(in_sprite), int'(vt[i].exp));
        end

        x = 11'd100; y = 10'd50; mirror = 1'b0;
        start = 1'b1; loop = 1'b0; tick(); start = 1'b0;
        chk("oneshot_busy", int'(busy), 1);
        pulses(7);  chk("oneshot_f0_hold", int'(frame_idx), 0);
        pulses(1);  chk("oneshot_f1", int'(frame_idx), 1);
        pulses(8);  chk("oneshot_f2", int'(frame_idx), 2);
        pulses(8);  chk("oneshot_f3", int'(frame_idx), 3);
        pulses(7);
        chk("oneshot_pre_done", int'(done), 0);
        chk("oneshot_pre_busy", int'(busy), 1);
        nf = 1'b1; tick(); nf = 1'b0;
        chk("oneshot_done", int'(done), 1);
        chk("oneshot_done_busy", int'(busy), 0);
        chk("oneshot_done_frame", int'(frame_idx), 3);
        tick();
        chk("oneshot_done_pulse", int'(done), 0);
        pulses(1);
        chk("done_stays_frame", int'(frame_idx), 3);
        chk("done_stays_busy", int'(busy), 0);
        h = 11'd100; v = 10'd50; tick(2);
        chk("done_f3_col0", int'(in_sprite), 1);
        h = 11'd108; tick(2);
        chk("done_f3_col2", int'(in_sprite), 0);

        start = 1'b1; loop = 1'b1; tick(); start = 1'b0; loop = 1'b0;
        pulses(31); chk("loop_f3", int'(frame_idx), 3);
        nf = 1'b1; tick(); nf = 1'b0;
        chk("loop_wrap_frame", int'(frame_idx), 0);
        chk("loop_no_done", int'(done), 0);
        chk("loop_busy", int'(busy), 1);
        tick();
        pulses(16); chk("loop_f2", int'(frame_idx), 2);
        pulses(3);
        start = 1'b1; nf = 1'b1; loop = 1'b1; tick(); start = 1'b0; nf = 1'b0;
        chk("restart_frame", int'(frame_idx), 0);
        pulses(7);  chk("restart_hold_clear", int'(frame_idx), 0);
        pulses(1);  chk("restart_f1", int'(frame_idx), 1);
        pulses(8);  chk("restart_f2", int'(frame_idx), 2);

        h = 11'd100; v = 10'd50; tick(2);
        chk("pre_reset_pixel", int'(in_sprite), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_sprite", int'(in_sprite), 0);
        chk("async_rst_frame", int'(frame_idx), 0);
        chk("async_rst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        tick(3);
        chk("post_reset_idle_pixel", int'(in_sprite), 0);
        chk("post_reset_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
